// File: rtl/alu_seq_pkg.sv
////////////////////////////////////////////////////////////////////////////
// alu_seq_pkg : opcodes, ALU opcodes, FSM states, instruction fields
// Revision 1.0 - initial release
////////////////////////////////////////////////////////////////////////////
`default_nettype none

package alu_seq_pkg;

   localparam int IW        = 10;
   localparam int IR_OPC_HI = 9;
   localparam int IR_OPC_LO = 7;
   localparam int IR_IMM_HI = 4;
   localparam int IR_IMM_LO = 0;

   localparam logic [2:0] OPC_ADD = 3'b000;
   localparam logic [2:0] OPC_OR  = 3'b001;
   localparam logic [2:0] OPC_SHL = 3'b010;
   localparam logic [2:0] OPC_LDI = 3'b011;
   localparam logic [2:0] OPC_JMP = 3'b100;
   localparam logic [2:0] OPC_JZ  = 3'b101;
   localparam logic [2:0] OPC_JS  = 3'b110;
   localparam logic [2:0] OPC_HLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_OR  = 2'b01;
   localparam logic [1:0] ALUOP_SHL = 2'b10;
   localparam logic [1:0] ALUOP_NOP = 2'b11;

   // Jump condition selects; flag register layout is {SF,ZF}
   localparam logic [1:0] JC_ALWAYS = 2'b00;
   localparam logic [1:0] JC_ZF     = 2'b01;
   localparam logic [1:0] JC_SF     = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
`ifdef ALU_SEQUENCER_STEP_EN
      ,
      ST_WAIT_STEP = 3'd5
`endif
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_decode.sv
////////////////////////////////////////////////////////////////////////////
// alu_seq_decode : combinational opcode to control-field mapping
// Revision 1.0 - initial release
////////////////////////////////////////////////////////////////////////////
`default_nettype none

module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [2:0] i_opc,
   output logic [1:0] o_alu_op,
   output logic       o_is_alu,
   output logic       o_is_ldi,
   output logic       o_is_jmp,
   output logic [1:0] o_jmp_cond,
   output logic       o_is_hlt
);

   always_comb begin
      o_alu_op   = ALUOP_NOP;
      o_is_alu   = 1'b0;
      o_is_ldi   = 1'b0;
      o_is_jmp   = 1'b0;
      o_jmp_cond = JC_ALWAYS;
      o_is_hlt   = 1'b0;
      case (i_opc)
         OPC_ADD: begin o_alu_op = ALUOP_ADD; o_is_alu = 1'b1; end
         OPC_OR:  begin o_alu_op = ALUOP_OR;  o_is_alu = 1'b1; end
         OPC_SHL: begin o_alu_op = ALUOP_SHL; o_is_alu = 1'b1; end
         OPC_LDI: o_is_ldi = 1'b1;
         OPC_JMP: o_is_jmp = 1'b1;
         OPC_JZ:  begin o_is_jmp = 1'b1; o_jmp_cond = JC_ZF; end
         OPC_JS:  begin o_is_jmp = 1'b1; o_jmp_cond = JC_SF; end
         default: o_is_hlt = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
////////////////////////////////////////////////////////////////////////////
// alu_sequencer : fetch/decode/exec controller for the 5-bit ALU CPU
// Revision 1.0 - ALU_SEQUENCER_STEP_EN adds i_step single-step mode
////////////////////////////////////////////////////////////////////////////
`default_nettype none

module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int            DW       = 5,
   parameter logic [DW-1:0] RESET_PC = '0
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_run,
`ifdef ALU_SEQUENCER_STEP_EN
   input  logic          i_step,
`endif
   output logic [DW-1:0] o_rom_addr,
   output logic          o_rom_req,
   input  logic [IW-1:0] i_rom_data,
   input  logic          i_rom_vld,
   output logic [DW-1:0] o_alu_a,
   output logic [DW-1:0] o_alu_b,
   output logic [1:0]    o_alu_op,
   input  logic [DW-1:0] i_alu_r,
   input  logic          i_alu_sf,
   input  logic          i_alu_zf,
   output logic [DW-1:0] o_acc,
   output logic [1:0]    o_flags,
   output logic          o_busy,
   output logic          o_halted
);

   state_t          r_state;
   logic [DW-1:0]   r_pc;
   logic [DW-1:0]   r_acc;
   logic [IW-1:0]   r_ir;
   logic [1:0]      r_flags;

   logic [2:0]      w_opc;
   logic [DW-1:0]   w_imm;
   logic [1:0]      w_alu_op;
   logic            w_is_alu;
   logic            w_is_ldi;
   logic            w_is_jmp;
   logic [1:0]      w_jmp_cond;
   logic            w_is_hlt;
   logic            w_jmp_taken;

   assign w_opc = r_ir[IR_OPC_HI:IR_OPC_LO];
   assign w_imm = r_ir[IR_IMM_HI:IR_IMM_LO];

   alu_seq_decode u_decode (
      .i_opc      (w_opc),
      .o_alu_op   (w_alu_op),
      .o_is_alu   (w_is_alu),
      .o_is_ldi   (w_is_ldi),
      .o_is_jmp   (w_is_jmp),
      .o_jmp_cond (w_jmp_cond),
      .o_is_hlt   (w_is_hlt)
   );

   // Jumps look at the flags as they stood before this instruction
   assign w_jmp_taken = w_is_jmp &&
                        ((w_jmp_cond == JC_ALWAYS) ||
                         ((w_jmp_cond == JC_ZF) && r_flags[0]) ||
                         ((w_jmp_cond == JC_SF) && r_flags[1]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_acc   <= '0;
         r_ir    <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_run) r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (i_rom_vld) begin
                  r_ir    <= i_rom_data;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_state <= w_is_hlt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
               if (w_is_alu) begin
                  r_acc   <= i_alu_r;
                  r_flags <= {i_alu_sf, i_alu_zf};
               end else if (w_is_ldi) begin
                  r_acc   <= w_imm;
               end
               r_pc <= w_jmp_taken ? w_imm : r_pc + DW'(1);
`ifdef ALU_SEQUENCER_STEP_EN
               r_state <= ST_WAIT_STEP;
`else
               r_state <= ST_FETCH;
`endif
            end
`ifdef ALU_SEQUENCER_STEP_EN
            ST_WAIT_STEP: begin
               if (i_step) r_state <= ST_FETCH;
            end
`endif
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Request and opcode decode straight from the state flop so reset drops them at once
   assign o_rom_addr = r_pc;
   assign o_rom_req  = (r_state == ST_FETCH);
   assign o_alu_a    = r_acc;
   assign o_alu_b    = w_imm;
   assign o_alu_op   = ((r_state == ST_EXEC) && w_is_alu) ? w_alu_op : ALUOP_NOP;
   assign o_acc      = r_acc;
   assign o_flags    = r_flags;
   assign o_busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                       (r_state == ST_EXEC);
   assign o_halted   = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
////////////////////////////////////////////////////////////////////////////
// tb_alu_sequencer : directed vector table plus multi-cycle sequences
// Revision 1.0 - initial release
////////////////////////////////////////////////////////////////////////////
`default_nettype none

module tb_alu_sequencer;

   localparam logic [2:0] T_ADD = 3'b000, T_OR = 3'b001, T_SHL = 3'b010, T_LDI = 3'b011;
   localparam logic [2:0] T_JMP = 3'b100, T_JZ = 3'b101, T_JS = 3'b110, T_HLT = 3'b111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [4:0] rom_addr;
   logic       rom_req;
   logic [9:0] rom_data;
   logic       rom_vld;
   logic [4:0] alu_a, alu_b, alu_r;
   logic [1:0] alu_op;
   logic       alu_sf, alu_zf;
   logic [4:0] acc;
   logic [1:0] flags;
   logic       busy, halted;

   logic [9:0] rom [32];
   int         rom_lat = 0;
   int         wait_cnt = 0;
   logic       force_vld = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_run      (run),
      .o_rom_addr (rom_addr),
      .o_rom_req  (rom_req),
      .i_rom_data (rom_data),
      .i_rom_vld  (rom_vld),
      .o_alu_a    (alu_a),
      .o_alu_b    (alu_b),
      .o_alu_op   (alu_op),
      .i_alu_r    (alu_r),
      .i_alu_sf   (alu_sf),
      .i_alu_zf   (alu_zf),
      .o_acc      (acc),
      .o_flags    (flags),
      .o_busy     (busy),
      .o_halted   (halted)
   );

   // External 5-bit ALU
   always_comb begin
      alu_r = 5'd0;
      case (alu_op)
         2'b00:   alu_r = alu_a + alu_b;
         2'b01:   alu_r = alu_a | alu_b;
         2'b10:   alu_r = (alu_b >= 5'd5) ? 5'd0 : (alu_a << alu_b);
         default: alu_r = 5'd0;
      endcase
      alu_sf = alu_r[4];
      alu_zf = (alu_r == 5'd0);
   end

   // Program ROM answering after rom_lat request cycles
   assign rom_data = rom[rom_addr];
   assign rom_vld  = (rom_req && (wait_cnt >= rom_lat)) || force_vld;

   always_ff @(posedge clk) begin
      if (!rom_req || rom_vld) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
   end

   function automatic logic [9:0] ins(input logic [2:0] opc, input logic [4:0] imm);
      return {opc, 2'b00, imm};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = ins(T_HLT, 5'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic start();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_halted(input string name, input int budget);
      int c = 0;
      while (!halted && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (!halted) check({name, "_halt_timeout"}, 0, 1);
   endtask

   task automatic wait_req(input logic level, input string name, input int budget);
      int c = 0;
      while (rom_req != level && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (rom_req != level) check({name, "_req_timeout"}, int'(rom_req), int'(level));
   endtask

   typedef struct {
      logic [9:0] i0, i1, i2;
      logic [4:0] e_acc;
      logic [1:0] e_fl;
      logic [4:0] e_pc;
   } vec_t;

   vec_t vt [12];

   initial begin
      int acc_q[$];
      int add_cycles, busy_cycles, req_cycles;
      logic [4:0] prev_acc;

      vt[0]  = '{ins(T_LDI,5'd3),  ins(T_ADD,5'd4),  ins(T_HLT,5'd0),  5'd7,  2'b00, 5'd2};
      vt[1]  = '{ins(T_LDI,5'd30), ins(T_ADD,5'd3),  ins(T_HLT,5'd0),  5'd1,  2'b00, 5'd2};
      vt[2]  = '{ins(T_LDI,5'd30), ins(T_ADD,5'd2),  ins(T_JZ,5'd9),   5'd0,  2'b01, 5'd9};
      vt[3]  = '{ins(T_LDI,5'd16), ins(T_OR,5'd0),   ins(T_JZ,5'd0),   5'd16, 2'b10, 5'd3};
      vt[4]  = '{ins(T_LDI,5'd16), ins(T_OR,5'd0),   ins(T_JS,5'd20),  5'd16, 2'b10, 5'd20};
      vt[5]  = '{ins(T_LDI,5'd7),  ins(T_SHL,5'd5),  ins(T_HLT,5'd0),  5'd0,  2'b01, 5'd2};
      vt[6]  = '{ins(T_LDI,5'd7),  ins(T_SHL,5'd2),  ins(T_HLT,5'd0),  5'd28, 2'b10, 5'd2};
      vt[7]  = '{ins(T_LDI,5'd5),  ins(T_JMP,5'd31), ins(T_HLT,5'd0),  5'd5,  2'b00, 5'd31};
      vt[8]  = '{ins(T_LDI,5'd0),  ins(T_ADD,5'd0),  ins(T_JS,5'd4),   5'd0,  2'b01, 5'd3};
      vt[9]  = '{ins(T_LDI,5'd1),  ins(T_OR,5'd8),   ins(T_JZ,5'd12),  5'd9,  2'b00, 5'd3};
      vt[10] = '{ins(T_LDI,5'd31), ins(T_ADD,5'd1),  ins(T_JS,5'd6),   5'd0,  2'b01, 5'd3};
      vt[11] = '{ins(T_LDI,5'd15), ins(T_SHL,5'd1),  ins(T_JS,5'd25),  5'd30, 2'b10, 5'd25};

      clear_rom();

      // Reset and start
      do_reset();
      repeat (5) @(negedge clk);
      check("rst_req",    int'(rom_req),  0);
      check("rst_pc",     int'(rom_addr), 0);
      check("rst_acc",    int'(acc),      0);
      check("rst_flags",  int'(flags),    0);
      check("rst_busy",   int'(busy),     0);
      check("rst_halted", int'(halted),   0);
      check("rst_aluop",  int'(alu_op),   3);
      start();
      check("start_req",  int'(rom_req),  1);
      check("start_addr", int'(rom_addr), 0);

      // Table of three-instruction programs
      for (int v = 0; v < 12; v++) begin
         clear_rom();
         rom[0] = vt[v].i0;
         rom[1] = vt[v].i1;
         rom[2] = vt[v].i2;
         rom_lat = 0;
         do_reset();
         start();
         wait_halted($sformatf("v%0d", v), 60);
         check($sformatf("v%0d_acc", v),   int'(acc),      int'(vt[v].e_acc));
         check($sformatf("v%0d_flags", v), int'(flags),    int'(vt[v].e_fl));
         check($sformatf("v%0d_pc", v),    int'(rom_addr), int'(vt[v].e_pc));
      end

      // Arithmetic program with per-cycle observation
      clear_rom();
      rom[0] = ins(T_LDI, 5'd3);
      rom[1] = ins(T_ADD, 5'd4);
      rom[2] = ins(T_SHL, 5'd1);
      rom[3] = ins(T_OR,  5'd1);
      do_reset();
      start();
      prev_acc = acc;
      add_cycles = 0;
      busy_cycles = 0;
      for (int c = 0; c < 100 && !halted; c++) begin
         if (acc != prev_acc) acc_q.push_back(int'(acc));
         prev_acc = acc;
         if (alu_op == 2'b00) add_cycles++;
         if (busy) busy_cycles++;
         @(negedge clk);
      end
      if (acc != prev_acc) acc_q.push_back(int'(acc));
      check("arith_halted",  int'(halted), 1);
      check("arith_nchg",    acc_q.size(), 4);
      if (acc_q.size() == 4) begin
         check("arith_acc0", acc_q[0], 3);
         check("arith_acc1", acc_q[1], 7);
         check("arith_acc2", acc_q[2], 14);
         check("arith_acc3", acc_q[3], 15);
      end
      check("arith_flags",   int'(flags), 0);
      check("arith_add_op",  add_cycles, 1);
      check("arith_busy",    busy_cycles, 14);

      // ROM wait states and PC wrap
      clear_rom();
      rom[0]  = ins(T_JMP, 5'd31);
      rom[31] = ins(T_LDI, 5'd5);
      rom_lat = 3;
      do_reset();
      start();
      req_cycles = 0;
      while (rom_req && req_cycles < 20) begin
         req_cycles++;
         @(negedge clk);
      end
      check("wait_req_cycles", req_cycles, 4);
      wait_req(1'b1, "wait_fetch31", 10);
      check("wait_addr31", int'(rom_addr), 31);
      wait_req(1'b0, "wait_dec31", 10);
      wait_req(1'b1, "wait_fetch0", 10);
      check("wrap_addr", int'(rom_addr), 0);
      check("wrap_acc",  int'(acc), 5);
      rom_lat = 0;

      // HLT holds PC, RUN ignored
      clear_rom();
      rom[0] = ins(T_LDI, 5'd1);
      rom[1] = ins(T_ADD, 5'd1);
      do_reset();
      start();
      wait_halted("hlt", 40);
      check("hlt_pc",   int'(rom_addr), 2);
      check("hlt_acc",  int'(acc), 2);
      check("hlt_busy", int'(busy), 0);
      for (int c = 0; c < 4; c++) begin
         run = c[0];
         @(negedge clk);
      end
      run = 1'b0;
      check("hlt_still",  int'(halted),   1);
      check("hlt_pc2",    int'(rom_addr), 2);
      check("hlt_noreq",  int'(rom_req),  0);

      // Reset during a stalled fetch, then a stray strobe
      rom_lat = 1000;
      do_reset();
      start();
      repeat (2) @(negedge clk);
      check("stall_req", int'(rom_req), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req",  int'(rom_req), 0);
      check("arst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      rom_lat = 0;
      force_vld = 1'b1;
      @(negedge clk);
      force_vld = 1'b0;
      repeat (2) @(negedge clk);
      check("late_vld_req",    int'(rom_req),  0);
      check("late_vld_busy",   int'(busy),     0);
      check("late_vld_halted", int'(halted),   0);
      check("late_vld_pc",     int'(rom_addr), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
